memreaddata_ctrl: RTL

//  M-stage load-return unit: the read-side counterpart of the store byte-lane steering.

---
 rtl/memreaddata_ctrl_if.sv | 21 ++
 rtl/memreaddata_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/memreaddata_ctrl_if.sv
// Data-side SRAM-like bus between the load-return unit and memory.
// Request/address/size flow out; address-accept, data-valid and read data flow back.
// The master modport is the load unit, the slave modport is the memory side.
interface memreaddata_ctrl_if;
  logic        data_req;
  logic [31:0] data_addr;
  logic [1:0]  data_size;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_addr, data_size,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_addr, data_size,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/memreaddata_ctrl.sv
// M-stage load-return unit: issues one bus read per load, steers and extends the returned lane.
// Latency: result registered 3 cycles after the load appears when addr_ok/data_ok come back immediately.
// Backpressure: stallM holds the pipeline while a request is outstanding; flush drops the result.
module memreaddata_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           op,
  input  logic                 memreadM,
  input  logic [31:0]          aluoutM,
  input  logic                 flushM,
  memreaddata_ctrl_if.master   bus,
  output logic [31:0]          readdataM,
  output logic                 rdvalidM,
  output logic                 stallM,
  output logic                 adelM
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t      state, state_nxt;
  logic        is_byte, is_half, is_word, is_signed;
  logic        load_go;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data;

  // Opcode decode; anything that is not a byte/half load is handled as a word load.
  always_comb begin
    is_byte   = (op == OP_LB) || (op == OP_LBU);
    is_half   = (op == OP_LH) || (op == OP_LHU);
    is_word   = !(is_byte || is_half);
    is_signed = (op == OP_LB) || (op == OP_LH);
    adelM     = memreadM && ((is_half && aluoutM[0]) || (is_word && (aluoutM[1:0] != 2'b00)));
    load_go   = memreadM && !adelM && !flushM;
  end

  // Lane selection and sign/zero extension using the offset captured when the request started.
  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = bus.data_rdata[7:0];
      2'd1:    byte_sel = bus.data_rdata[15:8];
      2'd2:    byte_sel = bus.data_rdata[23:16];
      default: byte_sel = bus.data_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
    case (size_q)
      2'd0:    ext_data = sign_q ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
      2'd1:    ext_data = sign_q ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
      default: ext_data = bus.data_rdata;
    endcase
  end

  // Address passes straight through; size comes from the captured decode so it is stable in REQ.
  assign bus.data_addr = aluoutM;
  assign bus.data_size = size_q;

  // Next-state and handshake/stall outputs.
  always_comb begin
    state_nxt    = state;
    bus.data_req = 1'b0;
    stallM       = 1'b0;
    rdvalidM     = 1'b0;
    case (state)
      S_IDLE: begin
        stallM = load_go;
        if (load_go) state_nxt = S_REQ;
      end
      S_REQ: begin
        bus.data_req = 1'b1;
        stallM       = !flushM;
        // An accepted address must be drained even if the instruction was flushed.
        if (bus.data_addr_ok)  state_nxt = flushM ? S_DRAIN : S_WAIT;
        else if (flushM)       state_nxt = S_IDLE;
      end
      S_WAIT: begin
        stallM = !flushM;
        if (bus.data_data_ok)  state_nxt = S_DONE;
        else if (flushM)       state_nxt = S_DRAIN;
      end
      S_DONE: begin
        rdvalidM  = 1'b1;
        state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (bus.data_data_ok) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, request-context capture and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      readdataM <= 32'd0;
      lane_q    <= 2'd0;
      size_q    <= 2'd0;
      sign_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && load_go) begin
        lane_q <= aluoutM[1:0];
        size_q <= is_byte ? 2'd0 : (is_half ? 2'd1 : 2'd2);
        sign_q <= is_signed;
      end
      if (state == S_WAIT && bus.data_data_ok) readdataM <= ext_data;
    end
  end

endmodule
